// File: rtl/mmio_pkg.sv
// Shared register map, bit positions and window decode for the memory-mapped timer.
// Latency: n/a (constants and a pure decode function). Backpressure: n/a.
// Consumed by mmio_timer and mmio_prescaler.
package mmio_pkg;

    localparam int WIN_ADDR_BITS = 5;
    localparam int PSC_W         = 16;

    // Register index = byte offset >> 2
    localparam logic [2:0] TMR_CTRL  = 3'd0;
    localparam logic [2:0] TMR_COUNT = 3'd1;
    localparam logic [2:0] TMR_CMP   = 3'd2;
    localparam logic [2:0] TMR_STAT  = 3'd3;
    localparam logic [2:0] TMR_PSC   = 3'd4;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_AUTO_RLD = 1;
    localparam int CTRL_IRQ_EN   = 2;
    localparam int STAT_MATCH    = 0;

    function automatic logic window_hit(input logic [31:0] addr, input logic [31:0] base);
        return addr[31:WIN_ADDR_BITS] == base[31:WIN_ADDR_BITS];
    endfunction

endpackage

// File: rtl/mmio_prescaler.sv
// Tick divider: one tick every (count+1) enabled cycles; instantiated under MMIO_TIMER_PRESCALE_EN.
// Latency: tick is combinational from the divider state. Backpressure: none, free-running.
// Disabled holds the divider at 0; load restarts it at 0.
module mmio_prescaler
    import mmio_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [PSC_W-1:0] count,
    output logic             tick
);

    logic [PSC_W-1:0] div_q;

    assign tick = enable && (div_q == count);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q <= '0;
        end else if (!enable || load || tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

endmodule

// File: rtl/mmio_timer.sv
// MMIO timer/compare peripheral with auto-reload and level irq; prescaler under MMIO_TIMER_PRESCALE_EN.
// Latency: reads combinational (0 cycles); writes visible the cycle after the store edge.
// Backpressure: none, every bus access completes in its own cycle.
module mmio_timer
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_FF00,
    parameter logic [31:0] RESET_CMP = 32'hFFFF_FFFF
)(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] read_address,
    input  logic [31:0] write_address,
    input  logic [31:0] write_data,
    input  logic        mem_write,
    output logic [31:0] read_data,
    output logic        rd_hit,
    output logic        irq
);

    logic [2:0]  ctrl_q;
    logic [31:0] count_q;
    logic [31:0] cmp_q;
    logic        match_q;
    logic        tick;
    logic        is_match;
    logic        wr_en;
    logic [2:0]  wr_idx;
    logic [2:0]  rd_idx;

    // Byte lanes are not decoded; low address bits are accepted and dropped
    logic unused_addr_bits;
    assign unused_addr_bits = ^{read_address[1:0], write_address[1:0]};

    assign wr_en  = mem_write && window_hit(write_address, BASE_ADDR);
    assign wr_idx = write_address[WIN_ADDR_BITS-1:2];
    assign rd_hit = window_hit(read_address, BASE_ADDR);
    assign rd_idx = read_address[WIN_ADDR_BITS-1:2];

`ifdef MMIO_TIMER_PRESCALE_EN
    logic [PSC_W-1:0] psc_q;
    logic             psc_wr;

    assign psc_wr = wr_en && (wr_idx == TMR_PSC);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            psc_q <= '0;
        end else if (psc_wr) begin
            psc_q <= write_data[PSC_W-1:0];
        end
    end

    mmio_prescaler u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .enable (ctrl_q[CTRL_EN]),
        .load   (psc_wr),
        .count  (psc_q),
        .tick   (tick)
    );
`else
    assign tick = ctrl_q[CTRL_EN];
`endif

    // Compare uses the pre-edge count, so a match still registers when the CPU overwrites COUNT
    assign is_match = tick && (count_q == cmp_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q  <= '0;
            count_q <= '0;
            cmp_q   <= RESET_CMP;
            match_q <= 1'b0;
        end else begin
            if (wr_en && (wr_idx == TMR_CTRL)) begin
                ctrl_q <= write_data[2:0];
            end
            if (wr_en && (wr_idx == TMR_CMP)) begin
                cmp_q <= write_data;
            end
            if (wr_en && (wr_idx == TMR_COUNT)) begin
                count_q <= write_data;
            end else if (tick) begin
                count_q <= (is_match && ctrl_q[CTRL_AUTO_RLD]) ? 32'd0 : count_q + 32'd1;
            end
            // Set has priority over write-one-to-clear
            if (is_match) begin
                match_q <= 1'b1;
            end else if (wr_en && (wr_idx == TMR_STAT) && write_data[STAT_MATCH]) begin
                match_q <= 1'b0;
            end
        end
    end

    assign irq = match_q && ctrl_q[CTRL_IRQ_EN];

    always_comb begin
        read_data = 32'd0;
        if (rd_hit) begin
            case (rd_idx)
                TMR_CTRL:  read_data = {29'd0, ctrl_q};
                TMR_COUNT: read_data = count_q;
                TMR_CMP:   read_data = cmp_q;
                TMR_STAT:  read_data = {31'd0, match_q};
`ifdef MMIO_TIMER_PRESCALE_EN
                TMR_PSC:   read_data = {{(32-PSC_W){1'b0}}, psc_q};
`endif
                default:   read_data = 32'd0;
            endcase
        end
    end

endmodule
